// File: rtl/osd_rom_arbiter.sv
// osd_rom_arbiter: round-robin arbiter and tagged read sequencer sharing the OSD glyph ROM
module osd_rom_arbiter #(
  parameter int PORT_NUM = 5,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [PORT_NUM-1:0]        i_req,
  input  logic [PORT_NUM*ADDR_W-1:0] i_addr,
  output logic [PORT_NUM-1:0]        o_ack,
  output logic [PORT_NUM-1:0]        o_rom_sel,
  output logic [ADDR_W-1:0]          o_rom_addr,
  input  logic [DATA_W-1:0]          i_rom_data,
  output logic [PORT_NUM-1:0]        o_rvalid,
  output logic [DATA_W-1:0]          o_rdata
);
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  logic [PW-1:0] ptr_q, ptr_d, win_idx;
  logic found;
  logic [PORT_NUM-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0][PORT_NUM-1:0] tag_q, tag_d;
  // first requester at or after ptr wins; nothing is granted while in reset
  always_comb begin
    found = 1'b0;
    win_idx = ptr_q;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (!found && i_req[(int'(ptr_q) + i) % PORT_NUM]) begin
        found = 1'b1;
        win_idx = PW'((int'(ptr_q) + i) % PORT_NUM);
      end
    end
    found = found & ~i_rst;
  end
  // grant, ROM request and tag pipeline next state
  always_comb begin
    o_ack = found ? PORT_NUM'(1) << win_idx : '0;
    sel_d = o_ack;
    addr_d = found ? i_addr[int'(win_idx)*ADDR_W +: ADDR_W] : addr_q;
    ptr_d = !found ? ptr_q : (int'(win_idx) == PORT_NUM - 1) ? '0 : win_idx + PW'(1);
    tag_d = tag_q;
    tag_d[0] = sel_q;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end
  // state registers; reset also drops every read still in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      addr_q <= '0;
      tag_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      addr_q <= addr_d;
      tag_q  <= tag_d;
    end
  end
  assign o_rom_sel  = sel_q;
  assign o_rom_addr = addr_q;
  assign o_rvalid   = tag_q[RD_LAT-1];
  assign o_rdata    = |o_rvalid ? i_rom_data : '0;
endmodule

// File: tb/tb_osd_rom_arbiter.sv
// tb_osd_rom_arbiter: directed checks of arbitration order, read latency, reset flush and idle behaviour
module tb_osd_rom_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [4:0] req, ack, sel, rv;
  logic [64:0] addr;
  logic [12:0] raddr;
  logic [15:0] rom_d, rdata;
  logic [2:0] req2, ack2, sel2, rv2;
  logic [38:0] addr2;
  logic [12:0] raddr2;
  logic [15:0] rdata2;
  logic [15:0] p2 [3];
  int n_tests = 0;
  int n_fail = 0;
  int exp3 [8] = '{2, 8, 2, 8, 16, 2, 8, 16};

  osd_rom_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .o_ack(ack),
    .o_rom_sel(sel), .o_rom_addr(raddr), .i_rom_data(rom_d),
    .o_rvalid(rv), .o_rdata(rdata)
  );
  osd_rom_arbiter #(.PORT_NUM(3), .ADDR_W(13), .DATA_W(16), .RD_LAT(3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_addr(addr2), .o_ack(ack2),
    .o_rom_sel(sel2), .o_rom_addr(raddr2), .i_rom_data(p2[2]),
    .o_rvalid(rv2), .o_rdata(rdata2)
  );

  function automatic logic [15:0] rom_f(input logic [12:0] a);
    return {3'b000, a} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    rom_d <= rom_f(raddr);
    p2[0] <= rom_f(raddr2);
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; req2 = '0; addr = '0; addr2 = '0;
    step;
    step;
    req = 5'h1f;
    samp;
    check("rst_ack", 32'(ack), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_addr", 32'(raddr), 0);
    check("rst_rvalid", 32'(rv), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_ack2", 32'(ack2), 0);
    step;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) addr[k*13 +: 13] = 13'(32'h100 + k);
    addr[2*13 +: 13] = 13'h0123;
    req = 5'b00100;
    samp;
    check("t1_ack", 32'(ack), 32'h04);
    step;
    req = '0;
    samp;
    check("t1_sel", 32'(sel), 32'h04);
    check("t1_addr", 32'(raddr), 32'h0123);
    check("t1_rv_early", 32'(rv), 0);
    check("t1_ack_idle", 32'(ack), 0);
    step;
    samp;
    check("t1_rvalid", 32'(rv), 32'h04);
    check("t1_rdata", 32'(rdata), 32'(rom_f(13'h0123)));
    step;
    samp;
    check("t1_rv_end", 32'(rv), 0);
    check("t1_rdata_end", 32'(rdata), 0);
    check("t1_sel_end", 32'(sel), 0);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) addr[k*13 +: 13] = 13'(32'h100 + k);
    req = 5'h1f;
    for (int i = 0; i < 10; i++) begin
      samp;
      check("t2_ack", 32'(ack), 32'(1) << (i % 5));
      check("t2_rvalid", 32'(rv), (i < 2) ? 0 : 32'(1) << ((i - 2) % 5));
      if (i >= 2) check("t2_rdata", 32'(rdata), 32'(rom_f(13'(32'h100 + (i - 2) % 5))));
      step;
    end
    req = '0;
    samp;
    check("t2_rv_tail3", 32'(rv), 32'h08);
    step;
    samp;
    check("t2_rv_tail4", 32'(rv), 32'h10);
    step;
    for (int i = 0; i < 8; i++) begin
      req = (i < 4) ? 5'b01010 : 5'b11010;
      samp;
      check("t3_ack", 32'(ack), 32'(exp3[i]));
      step;
    end
    req = '0;
    step;
    step;
    addr[0 +: 13] = 13'h1abc;
    req = 5'b00011;
    samp;
    check("t4_ack", 32'(ack), 32'h01);
    check("t4_rv_pre", 32'(rv), 0);
    step;
    rst = 1'b1;
    samp;
    check("t4_rst_ack", 32'(ack), 0);
    check("t4_rst_sel", 32'(sel), 32'h01);
    check("t4_rst_rv", 32'(rv), 0);
    step;
    rst = 1'b0;
    samp;
    check("t4_post_ack", 32'(ack), 32'h01);
    check("t4_post_rv", 32'(rv), 0);
    check("t4_post_sel", 32'(sel), 0);
    step;
    req = '0;
    samp;
    check("t4_sel", 32'(sel), 32'h01);
    check("t4_addr", 32'(raddr), 32'h1abc);
    check("t4_rv_flushed", 32'(rv), 0);
    step;
    samp;
    check("t4_rvalid", 32'(rv), 32'h01);
    check("t4_rdata", 32'(rdata), 32'(rom_f(13'h1abc)));
    step;
    for (int i = 0; i < 10; i++) begin
      samp;
      check("t6_sel", 32'(sel), 0);
      check("t6_ack", 32'(ack), 0);
      check("t6_rv", 32'(rv), 0);
      check("t6_rdata", 32'(rdata), 0);
      check("t6_addr_hold", 32'(raddr), 32'h1abc);
      step;
    end
    for (int i = 0; i < 3; i++) begin
      addr2[0 +: 13] = 13'(i);
      req2 = 3'b001;
      samp;
      check("t5_ack2", 32'(ack2), 32'h1);
      step;
    end
    req2 = '0;
    for (int i = 3; i < 9; i++) begin
      samp;
      check("t5_rvalid2", 32'(rv2), (i >= 4 && i <= 6) ? 32'h1 : 0);
      check("t5_rdata2", 32'(rdata2), (i >= 4 && i <= 6) ? 32'(rom_f(13'(i - 4))) : 0);
      step;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/osd_rom_arbiter.md
# osd_rom_arbiter

Round-robin arbiter and read sequencer that shares the single OSD character/glyph ROM between up to PORT_NUM OSD requesters (text overlay, cursor, waveform labels, etc.). Each cycle it accepts at most one read request, drives a one-hot select plus registered address into the multiport ROM wrapper, and returns the ROM data to the winning port with a tagged valid strobe after a fixed latency. It sits between the OSD drawing engines and the multiport ROM wrapper in the la display path.

## Interface
- PORT_NUM, 5: number of requesters (2..8).
- ADDR_W, 13: ROM address width.
- DATA_W, 16: ROM data width.
- RD_LAT, 1: ROM read latency in cycles from the cycle the address is presented to the cycle data is valid (1..4).

- i_clk  in  1  system clock; all logic is on its rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req  in  PORT_NUM  per-port read request level; held with its address until acked.
- i_addr  in  PORT_NUM*ADDR_W  per-port read address, port k at [k*ADDR_W +: ADDR_W].
- o_ack  out  PORT_NUM  one-hot, combinational; request accepted this cycle.
- o_rom_sel  out  PORT_NUM  registered one-hot select to the ROM wrapper's request input; 0 when idle.
- o_rom_addr  out  ADDR_W  registered address to the ROM wrapper's per-port address of the selected port.
- i_rom_data  in  DATA_W  ROM read data (the selected port's data lane, or the shared lane).
- o_rvalid  out  PORT_NUM  one-hot, registered tag; read data for port k valid this cycle.
- o_rdata  out  DATA_W  equals i_rom_data when any o_rvalid bit is set, else 0.

## Operation
- Arbitration: round-robin over i_req with a priority pointer ptr (index, $clog2(PORT_NUM) bits). Search order ptr, ptr+1, …, wrapping modulo PORT_NUM; first set bit wins.
- On a win by port k: o_ack[k]=1 in the same cycle; on the clock edge o_rom_sel<=onehot(k), o_rom_addr<=i_addr[k], ptr<=(k+1) mod PORT_NUM.
- No request: o_ack=0, o_rom_sel<=0, o_rom_addr holds, ptr holds.
- One grant per cycle, back-to-back allowed, including the same port on consecutive cycles if it is the only requester.
- A requester sees o_ack[k] at a clock edge and either drops i_req[k] or presents the next address in the following cycle. If i_req stays high with the same address, it is read again; that is the requester's responsibility.
- Tag pipeline: shift register of RD_LAT stages, each PORT_NUM wide. Stage 0 is loaded from o_rom_sel, and the last stage drives o_rvalid. This guarantees exactly one o_rvalid pulse per o_ack pulse, in order.
- o_rdata is a pass-through of i_rom_data gated by |o_rvalid. It is not registered here, because the ROM output register provides the timing.
- Reset values: ptr=0 (port 0 highest priority), o_rom_sel=0, o_rom_addr=0, all tag stages 0, so o_rvalid=0 and o_rdata=0. o_ack is 0 during any cycle with i_rst=1 (no grants in reset).
- Reset mid-flight: all outstanding tags are discarded. No o_rvalid appears for requests acked before reset, including requests whose data would land after reset deasserts.
- Requests for ports ≥ PORT_NUM do not exist. Unused address bits are ignored.

## Timing
- Cycle t: i_req[k]=1 and port k wins, so o_ack[k]=1.
- Cycle t+1: o_rom_sel=onehot(k), o_rom_addr=addr.
- Cycle t+1+RD_LAT: o_rvalid[k]=1, o_rdata=ROM[addr].
- Total request-to-data latency: 1+RD_LAT cycles (2 with the default ROM).
- Throughput: 1 read per cycle aggregate. With N continuously requesting ports, each port gets one grant every N cycles.
- Worst-case wait for a held request: PORT_NUM-1 cycles from i_req rise to o_ack.
- First cycle after i_rst falls: arbitration is live and port 0 has priority.

## Test plan
- Single read, default params: i_req=5'b00100 with i_addr[2]=13'h0123 for one cycle → o_ack=00100 at t; o_rom_sel=00100 and o_rom_addr=0x0123 at t+1; o_rvalid=00100 and o_rdata=ROM[0x123] at t+2. All other cycles have o_rvalid=0.
- All five ports held high after reset → o_ack sequence 0,1,2,3,4,0,… with one grant per cycle. o_rvalid follows the same order, delayed 2 cycles. No gaps and no duplicates.
- Ports 1 and 3 held continuously, port 1 acked last → grants alternate 3,1,3,1. A port-4 request arriving mid-stream is acked within ≤4 cycles.
- Assert i_rst for one cycle while 2 reads are in flight → o_rvalid stays 0 for those reads. After release, i_req=00001 is acked immediately and data returns in 2 cycles.
- RD_LAT=3, PORT_NUM=3, back-to-back reads by port 0 at addresses 0,1,2 → three consecutive o_rvalid[0] pulses starting 4 cycles after the first ack, carrying ROM[0], ROM[1], ROM[2].
- Idle with i_req=0 for 10 cycles → o_rom_sel=0, o_ack=0, o_rvalid=0, o_rdata=0, and o_rom_addr holds its last value.
